// File: rtl/scalar_product_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scalar_product_feeder                                                    |
// | Packs a serial (a,b) stream into vectors for the dot-product engine,     |
// | sequences its clear and latency, and hands the result downstream.        |
// | Optional: SCALAR_PRODUCT_FEEDER_OVF_EN adds the res_ovf output.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scalar_product_feeder #(
  parameter int Nbits   = 4,
  parameter int Ndata   = 4,
  parameter int CLR_CYC = 2,
  parameter int RES_LAT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Nbits-1:0]         in_a,
  input  logic [Nbits-1:0]         in_b,
  output logic [Ndata*Nbits-1:0]   A,
  output logic [Ndata*Nbits-1:0]   B,
  output logic                     sp_reset,
  input  logic [2*Nbits-1:0]       sp_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*Nbits-1:0]       res_data
`ifdef SCALAR_PRODUCT_FEEDER_OVF_EN
  ,
  output logic                     res_ovf
`endif
);

  localparam int c_KW      = $clog2(Ndata);
  localparam int c_CNT_MAX = (CLR_CYC > RES_LAT) ? CLR_CYC : RES_LAT;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);

  localparam logic [c_KW-1:0] c_K_LAST  = c_KW'(Ndata - 1);
  localparam logic [c_CW-1:0] c_CLR_LD  = c_CW'(CLR_CYC - 1);
  localparam logic [c_CW-1:0] c_LAT_LD  = c_CW'(RES_LAT - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_KW-1:0]   r_k;
  logic [c_CW-1:0]   r_cnt;
  logic              w_accept;

  assign in_ready = (r_state == S_LOAD);
  assign w_accept = in_valid & in_ready;

`ifdef SCALAR_PRODUCT_FEEDER_OVF_EN
  localparam int c_AW = 2*Nbits + c_KW;

  logic [c_AW-1:0]      r_acc;
  logic [2*Nbits-1:0]   w_prod;

  assign w_prod = {{Nbits{1'b0}}, in_a} * {{Nbits{1'b0}}, in_b};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_LOAD;
      r_k       <= '0;
      r_cnt     <= '0;
      A         <= '0;
      B         <= '0;
      sp_reset  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef SCALAR_PRODUCT_FEEDER_OVF_EN
      r_acc     <= '0;
      res_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          sp_reset <= 1'b1;
          if (w_accept) begin
            A[r_k*Nbits +: Nbits] <= in_a;
            B[r_k*Nbits +: Nbits] <= in_b;
`ifdef SCALAR_PRODUCT_FEEDER_OVF_EN
            r_acc <= r_acc + c_AW'(w_prod);
`endif
            if (r_k == c_K_LAST) begin
              r_k     <= '0;
              r_cnt   <= c_CLR_LD;
              r_state <= S_CLEAR;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end

        S_CLEAR: begin
          if (r_cnt == '0) begin
            sp_reset <= 1'b0;
            r_cnt    <= c_LAT_LD;
            r_state  <= S_RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_RUN: begin
          // Engine output is taken as-is; its own truncation is preserved.
          if (r_cnt == '0) begin
            res_data  <= sp_out;
            res_valid <= 1'b1;
            sp_reset  <= 1'b1;
            r_state   <= S_HOLD;
`ifdef SCALAR_PRODUCT_FEEDER_OVF_EN
            res_ovf   <= |r_acc[c_AW-1:2*Nbits];
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= S_LOAD;
`ifdef SCALAR_PRODUCT_FEEDER_OVF_EN
            r_acc     <= '0;
            res_ovf   <= 1'b0;
`endif
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/scalar_product_feeder.md
Name: scalar_product_feeder

Overview:
- Producer/consumer front end for the scalar_product_mac_par dot-product engine.
- Accepts a serial stream of (a, b) element pairs over a valid/ready handshake and packs Ndata pairs into the engine's packed A/B vectors.
- Sequences the engine's active-high accumulator clear, waits a fixed compute latency, then captures the engine result and presents it downstream with a valid/ready handshake.

Parameters:
- Nbits, 4, element width in bits.
- Ndata, 4, elements per vector; must be ≥2.
- CLR_CYC, 2, cycles `sp_reset` is held high after a vector is loaded; must be ≥1.
- RES_LAT, 8, cycles with `sp_reset` low before `sp_out` is sampled; must be ≥1; sized for the engine's Nmac configuration.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  element pair valid.
- in_ready  out  1  feeder can accept an element pair.
- in_a  in  Nbits  element of vector A.
- in_b  in  Nbits  element of vector B.
- A  out  Ndata*Nbits  packed vector A to the engine.
- B  out  Ndata*Nbits  packed vector B to the engine.
- sp_reset  out  1  active-high clear driven to the engine.
- sp_out  in  2*Nbits  engine result.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  2*Nbits  captured result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOAD, element index k=0, A=0, B=0, sp_reset=1, res_valid=0, res_data=0, in_ready=1.
  - Applies immediately, including mid-LOAD, CLEAR, RUN or HOLD; a partial vector is discarded.
- States: LOAD, CLEAR, RUN, HOLD. All outputs are registered except in_ready.
- LOAD:
  - in_ready=1, sp_reset=1.
  - On an edge with in_valid&in_ready: A[k*Nbits +: Nbits]←in_a, B[k*Nbits +: Nbits]←in_b.
  - k increments; if k==Ndata-1, then k←0 and state→CLEAR.
  - in_valid low: nothing changes; no timeout.
- CLEAR:
  - in_ready=0, sp_reset=1 for exactly CLR_CYC cycles (down-counter), then →RUN.
  - A/B are frozen from here until HOLD exits.
- RUN:
  - sp_reset=0 for exactly RES_LAT cycles.
  - On the edge ending the last RUN cycle: res_data←sp_out, res_valid←1, sp_reset←1, state→HOLD.
- HOLD:
  - res_valid=1; res_data stable; sp_reset=1; in_ready=0.
  - On an edge with res_ready=1: res_valid←0, state→LOAD.
  - res_ready may be high before res_valid; a transfer occurs only when both are high.
- Latency:
  - Last element accepted at edge E.
  - sp_reset falls at edge E+CLR_CYC.
  - res_valid rises at edge E+CLR_CYC+RES_LAT.
- Throughput: one vector per Ndata+CLR_CYC+RES_LAT+1 cycles minimum. No overlap: elements for the next vector are refused until HOLD completes.
- Width rule: res_data is sp_out verbatim (2*Nbits, engine truncation preserved); no arithmetic on the main path.

Optional Feature:
- Macro SCALAR_PRODUCT_FEEDER_OVF_EN.
- Defined:
  - Adds an output res_ovf (1 bit) and an internal accumulator of width 2*Nbits+$clog2(Ndata).
  - Accumulator clears on reset and on entry to LOAD; adds in_a*in_b on each accepted element.
  - res_ovf←(accumulator > 2^(2*Nbits)-1) on the same edge res_data is captured; held with res_valid; 0 out of reset.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic: after reset, send pairs (a,b)=(1,6),(2,5),(3,4),(2,1); engine model returns the dot product.
  - A=16'h2321, B=16'h1456.
  - sp_reset low for exactly 8 cycles.
  - res_valid rises 10 edges after the last accept; res_data=30.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid. res_data stays 30, in_ready stays 0, and in_valid pulses are ignored; release → one transfer, then in_ready=1.
- Stalled input: insert random in_valid gaps between elements. Packing order and the result are unchanged, and CLEAR starts only after the 4th accept.
- Overflow (EN defined): pairs (15,15),(15,15),(15,15),(1,1).
  - res_data = model value (676 mod 256 = 164) and res_ovf=1.
  - A following vector {1,1,1,1}·{1,1,1,1} gives res_data=4, res_ovf=0.
- Reset mid-operation: assert reset in LOAD after 2 elements, and separately in RUN.
  - Outputs return to reset values immediately (asynchronously).
  - A subsequent full vector produces the correct result with no stale elements.
- Back-to-back: 3 vectors with res_ready tied high. Exactly 3 results in order, each separated by ≥Ndata+CLR_CYC+RES_LAT+1 cycles.
